// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
// ID/EX pipeline register for the 5-stage MIPS pipeline with built-in
// load-use hazard detection, branch squash and a saturating stall counter.
//
// Ports
//   clk, rst                 pipeline clock, synchronous active-high reset
//   i_if_id_valid            instruction in ID is real
//   i_if_id_registerrs/rt/rd register fields of the ID instruction
//   i_id_* control           decoded control bits and 4-bit ALU op
//   i_id_readdata1/2         register file read data
//   i_id_imm, i_id_pc        sign-extended immediate, PC+4
//   i_flush                  branch taken in EX, squash the ID instruction
//   o_id_ex_*                registered EX-stage copies of the above
//   o_stall                  combinational load-use stall request
//   o_pc_write, o_if_id_write  front-end write enables (inverse of stall)
//   o_stall_count            saturating count of stall cycles
// ---------------------------------------------------------------------------
module id_ex_stage #(
    parameter int DW   = 32,
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_if_id_valid,
    input  logic [4:0]      i_if_id_registerrs,
    input  logic [4:0]      i_if_id_registerrt,
    input  logic [4:0]      i_if_id_registerrd,
    input  logic            i_id_regwrite,
    input  logic            i_id_memread,
    input  logic            i_id_memwrite,
    input  logic            i_id_memtoreg,
    input  logic            i_id_alusrc,
    input  logic            i_id_regdst,
    input  logic [3:0]      i_id_aluop,
    input  logic [DW-1:0]   i_id_readdata1,
    input  logic [DW-1:0]   i_id_readdata2,
    input  logic [DW-1:0]   i_id_imm,
    input  logic [DW-1:0]   i_id_pc,
    input  logic            i_flush,
    output logic            o_id_ex_valid,
    output logic [4:0]      o_id_ex_registerrs,
    output logic [4:0]      o_id_ex_registerrt,
    output logic [4:0]      o_id_ex_registerrd,
    output logic            o_id_ex_regwrite,
    output logic            o_id_ex_memread,
    output logic            o_id_ex_memwrite,
    output logic            o_id_ex_memtoreg,
    output logic            o_id_ex_alusrc,
    output logic            o_id_ex_regdst,
    output logic [3:0]      o_id_ex_aluop,
    output logic [DW-1:0]   o_id_ex_readdata1,
    output logic [DW-1:0]   o_id_ex_readdata2,
    output logic [DW-1:0]   o_id_ex_imm,
    output logic [DW-1:0]   o_id_ex_pc,
    output logic            o_stall,
    output logic            o_pc_write,
    output logic            o_if_id_write,
    output logic [CNTW-1:0] o_stall_count
);

    logic            r_valid;
    logic [4:0]      r_rs;
    logic [4:0]      r_rt;
    logic [4:0]      r_rd;
    logic            r_regwrite;
    logic            r_memread;
    logic            r_memwrite;
    logic            r_memtoreg;
    logic            r_alusrc;
    logic            r_regdst;
    logic [3:0]      r_aluop;
    logic [DW-1:0]   r_readdata1;
    logic [DW-1:0]   r_readdata2;
    logic [DW-1:0]   r_imm;
    logic [DW-1:0]   r_pc;
    logic [CNTW-1:0] r_stall_count;

    logic            w_hazard;
    logic            w_stall;
    logic            w_bubble;

    // A load in EX whose destination is read by the ID instruction cannot be
    // forwarded in time. $zero is never a real dependency. A flush discards
    // the ID instruction, so there is nothing to hold and flush wins.
    assign w_hazard = r_valid & r_memread & (r_rt != 5'd0) & i_if_id_valid &
                      ((r_rt == i_if_id_registerrs) | (r_rt == i_if_id_registerrt));
    assign w_stall  = w_hazard & ~i_flush;
    assign w_bubble = i_flush | w_stall;

    assign o_stall       = w_stall;
    assign o_pc_write    = ~w_stall;
    assign o_if_id_write = ~w_stall;

    // Pipeline register. Bubbles zero every field so that no stale index or
    // regwrite/memwrite bit can ever trigger forwarding. An invalid ID slot
    // still captures its data but its control is forced off.
    always_ff @(posedge clk) begin
        if (rst || w_bubble) begin
            r_valid     <= 1'b0;
            r_rs        <= '0;
            r_rt        <= '0;
            r_rd        <= '0;
            r_regwrite  <= 1'b0;
            r_memread   <= 1'b0;
            r_memwrite  <= 1'b0;
            r_memtoreg  <= 1'b0;
            r_alusrc    <= 1'b0;
            r_regdst    <= 1'b0;
            r_aluop     <= '0;
            r_readdata1 <= '0;
            r_readdata2 <= '0;
            r_imm       <= '0;
            r_pc        <= '0;
        end else begin
            r_valid     <= i_if_id_valid;
            r_rs        <= i_if_id_registerrs;
            r_rt        <= i_if_id_registerrt;
            r_rd        <= i_if_id_registerrd;
            r_regwrite  <= i_if_id_valid & i_id_regwrite;
            r_memread   <= i_if_id_valid & i_id_memread;
            r_memwrite  <= i_if_id_valid & i_id_memwrite;
            r_memtoreg  <= i_if_id_valid & i_id_memtoreg;
            r_alusrc    <= i_if_id_valid & i_id_alusrc;
            r_regdst    <= i_if_id_valid & i_id_regdst;
            r_aluop     <= i_if_id_valid ? i_id_aluop : 4'd0;
            r_readdata1 <= i_id_readdata1;
            r_readdata2 <= i_id_readdata2;
            r_imm       <= i_id_imm;
            r_pc        <= i_id_pc;
        end
    end

    // Stall counter for performance measurement; sticks at all-ones
    // instead of wrapping so a long run never under-reports.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_count <= '0;
        end else if (w_stall && (r_stall_count != {CNTW{1'b1}})) begin
            r_stall_count <= r_stall_count + {{(CNTW-1){1'b0}}, 1'b1};
        end
    end

    assign o_id_ex_valid      = r_valid;
    assign o_id_ex_registerrs = r_rs;
    assign o_id_ex_registerrt = r_rt;
    assign o_id_ex_registerrd = r_rd;
    assign o_id_ex_regwrite   = r_regwrite;
    assign o_id_ex_memread    = r_memread;
    assign o_id_ex_memwrite   = r_memwrite;
    assign o_id_ex_memtoreg   = r_memtoreg;
    assign o_id_ex_alusrc     = r_alusrc;
    assign o_id_ex_regdst     = r_regdst;
    assign o_id_ex_aluop      = r_aluop;
    assign o_id_ex_readdata1  = r_readdata1;
    assign o_id_ex_readdata2  = r_readdata2;
    assign o_id_ex_imm        = r_imm;
    assign o_id_ex_pc         = r_pc;
    assign o_stall_count      = r_stall_count;

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register with integrated load-use hazard detection for the 5-stage MIPS pipeline. It captures decoded control, register operands and register indices from the ID stage each cycle. It supplies `id_ex_registerrs`, `id_ex_registerrt` and `id_ex_memwrite` directly to the forwarding unit. It inserts a one-cycle bubble on load-use hazards, squashes the ID instruction on a taken branch, and keeps a saturating stall counter for performance measurement.

## Interface
Parameters:
- `DW`, 32, datapath width (operands, immediate, PC)
- `CNTW`, 16, stall counter width

Ports:
- `clk` in 1 — pipeline clock, all state updates on rising edge
- `rst` in 1 — synchronous, active-high reset
- `if_id_valid` in 1 — IF/ID holds a real instruction
- `if_id_registerrs`, `if_id_registerrt`, `if_id_registerrd` in 5 each — register fields of instruction in ID
- `id_regwrite`, `id_memread`, `id_memwrite`, `id_memtoreg`, `id_alusrc`, `id_regdst` in 1 each — decoded control
- `id_aluop` in 4 — decoded ALU op
- `id_readdata1`, `id_readdata2`, `id_imm`, `id_pc` in DW each — register file outputs, sign-extended immediate, PC+4
- `flush` in 1 — branch taken in EX; squash instruction in ID
- `id_ex_valid` out 1 — EX holds a real instruction
- `id_ex_registerrs`, `id_ex_registerrt`, `id_ex_registerrd` out 5 each — to forwarding unit / EX dest mux
- `id_ex_regwrite`, `id_ex_memread`, `id_ex_memwrite`, `id_ex_memtoreg`, `id_ex_alusrc`, `id_ex_regdst` out 1 each
- `id_ex_aluop` out 4
- `id_ex_readdata1`, `id_ex_readdata2`, `id_ex_imm`, `id_ex_pc` out DW each
- `stall` out 1 — combinational hazard indication
- `pc_write`, `if_id_write` out 1 each — combinational; equal to `~stall`
- `stall_count` out CNTW — saturating count of stall cycles

## Operation
- Hazard detection (combinational, from registered EX state and current ID fields):
  - `hazard` = `id_ex_valid & id_ex_memread & (id_ex_registerrt != 0) & if_id_valid & (id_ex_registerrt == if_id_registerrs | id_ex_registerrt == if_id_registerrt)`
  - `stall` = `hazard & ~flush`. Flush wins: the ID instruction is discarded, so there is nothing to hold.
- Register update on each rising edge, in priority order:
  - `rst`: bubble state and `stall_count` = 0.
  - `flush` or `stall`: load a bubble. `id_ex_valid`, all control bits and `id_ex_aluop` are 0. Register indices, data fields, imm and pc are 0.
  - Otherwise: capture all ID inputs; `id_ex_valid` ← `if_id_valid`.
  - If `if_id_valid` = 0, the bubble rule applies to the control bits (they are forced to 0) while the data fields are still captured.
- Bubbles must never cause forwarding: `regwrite` = 0 and `memwrite` = 0 in every bubble.
- `stall_count` increments by 1 on every edge where `stall` = 1. It holds at all-ones (saturates) and never wraps.
- Reset values:
  - Every `id_ex_*` output = 0, `stall_count` = 0.
  - `stall` = 0, `pc_write` = `if_id_write` = 1 immediately after reset, since `id_ex_valid` = 0.

## Timing
- Latency: 1 cycle from ID inputs to `id_ex_*` outputs.
- Load-use stall lasts exactly 1 cycle:
  - The bubble clears `id_ex_memread`, so the same ID instruction is re-evaluated and passes on the next edge.
  - After that, the load is in MEM and its data is reached through forwarding.
- Back-to-back loads each feeding the next instruction produce one stall per dependent pair, never two consecutive stalls for the same ID instruction.
- `flush` and `hazard` in the same cycle:
  - `stall` = 0, bubble loaded, `stall_count` unchanged.
- `rst` asserted mid-stall:
  - Next edge yields a bubble and count 0.
  - `stall` deasserts combinationally once `id_ex_valid` = 0.
- `id_ex_registerrt` = 0 with `memread` = 1 never stalls, because $zero is never forwarded.

## Test plan
- Reset: hold `rst` for 2 cycles with arbitrary inputs → all `id_ex_*` = 0, `stall_count` = 0, `pc_write` = 1.
- Load-use: `lw $5` captured, then ID has rs = 5 → `stall` = 1 for exactly one cycle, next EX is a bubble (`id_ex_regwrite` = 0), the dependent instruction is in EX one cycle later, `stall_count` = 1.
- No hazard cases:
  - `lw $5` followed by ID using rs = 6, rt = 7 → no stall, the instruction passes directly.
  - `lw $0` followed by ID rs = 0 → no stall.
- Flush priority: `lw $3` in EX, ID rt = 3, `flush` = 1 the same cycle → `stall` = 0, bubble loaded, `stall_count` unchanged.
- Saturation: with CNTW = 4, force 20 load-use stalls → `stall_count` = 15 and stays at 15.
- Pass-through: a valid `add` with `id_readdata1` = 0x12345678, rs = 1, rt = 2, rd = 3, `regwrite` = 1 → next cycle the outputs match bit-exact and `id_ex_valid` = 1.
